// File: rtl/ebus_ctl.sv
// ebus_ctl: EBUS transfer sequencer for the EBOX data path.
//
// Takes a one-cycle I/O request from microcode control and runs one EBUS
// transaction. The sequence is: a setup phase with CS/FUNC stable, then a
// demand phase that waits for the device transfer acknowledge, then a release
// phase that waits for the acknowledge to drop. Read data is captured into
// ebusIn for the AR/ARX input mux. Each wait phase has its own timeout.
//
// Ports:
//   clk, resetN          EBOX clock; asynchronous active-low reset
//   start                one-cycle request, accepted only while idle
//   write, cs, func      transaction direction, controller select and function
//   ebusOut              outgoing data word, sampled with start on writes
//   ebusXfer             synchronized device transfer acknowledge
//   ebusDataIn           bus data returned by the device
//   ebusCS, ebusFunc     controller select and function driven to the bus
//   ebusDemand           EBOX demand
//   ebusData, ebusDrive  EBOX bus data and its drive enable (writes only)
//   ebusIn, ebusLoad     captured read word and its one-cycle update pulse
//   busy, done, timeout  in progress, completion pulse, sticky timeout error
//
// Every output is a flop, so no combinational path runs from the bus inputs
// to the outputs.
module ebus_ctl #(
    parameter int unsigned SETUP_CYCLES = 2,   // 1..15
    parameter int unsigned TIMEOUT      = 255  // 1..255
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic        write,
    input  logic [0:6]  cs,
    input  logic [0:2]  func,
    input  logic [0:35] ebusOut,
    input  logic        ebusXfer,
    input  logic [0:35] ebusDataIn,
    output logic [0:6]  ebusCS,
    output logic [0:2]  ebusFunc,
    output logic        ebusDemand,
    output logic [0:35] ebusData,
    output logic        ebusDrive,
    output logic [0:35] ebusIn,
    output logic        ebusLoad,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StDemand,
        StRelease
    } state_t;

    localparam logic [7:0] SetupLoad   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_write;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            ebusCS     <= '0;
            ebusFunc   <= '0;
            ebusDemand <= 1'b0;
            ebusData   <= '0;
            ebusDrive  <= 1'b0;
            ebusIn     <= '0;
            ebusLoad   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            // Pulses default low; they are raised for exactly one cycle below.
            ebusLoad <= 1'b0;
            done     <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state   <= StSetup;
                        busy      <= 1'b1;
                        r_write   <= write;
                        ebusCS    <= cs;
                        ebusFunc  <= func;
                        ebusDrive <= write;
                        // Reads leave the data lines at zero.
                        ebusData  <= write ? ebusOut : '0;
                        timeout   <= 1'b0;
                        r_cnt     <= SetupLoad;
                    end
                end

                StSetup: begin
                    if (r_cnt == 8'd0) begin
                        r_state    <= StDemand;
                        ebusDemand <= 1'b1;
                        r_cnt      <= TimeoutLoad;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                StDemand: begin
                    if (ebusXfer) begin
                        if (!r_write) begin
                            ebusIn   <= ebusDataIn;
                            ebusLoad <= 1'b1;
                        end
                        ebusDemand <= 1'b0;
                        r_cnt      <= TimeoutLoad;
                        r_state    <= StRelease;
                    end else if (r_cnt == 8'd0) begin
                        // No reload here: release finishes on the next cycle,
                        // with a second timeout if the device still holds xfer.
                        timeout <= 1'b1;
                        if (!r_write) begin
                            ebusIn   <= '0;
                            ebusLoad <= 1'b1;
                        end
                        ebusDemand <= 1'b0;
                        r_state    <= StRelease;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                StRelease: begin
                    if (!ebusXfer || (r_cnt == 8'd0)) begin
                        if (ebusXfer) begin
                            timeout <= 1'b1;
                        end
                        // Give the bus back as we return to idle.
                        r_state   <= StIdle;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        ebusCS    <= '0;
                        ebusFunc  <= '0;
                        ebusData  <= '0;
                        ebusDrive <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ebus_ctl.sv
// tb_ebus_ctl: directed bench for ebus_ctl (SETUP_CYCLES=2, TIMEOUT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ebus_ctl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic        write;
    logic [0:6]  cs;
    logic [0:2]  func;
    logic [0:35] ebusOut;
    logic        ebusXfer;
    logic [0:35] ebusDataIn;
    logic [0:6]  ebusCS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand;
    logic [0:35] ebusData;
    logic        ebusDrive;
    logic [0:35] ebusIn;
    logic        ebusLoad;
    logic        busy;
    logic        done;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ebus_ctl #(
        .SETUP_CYCLES(2),
        .TIMEOUT     (8)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .write     (write),
        .cs        (cs),
        .func      (func),
        .ebusOut   (ebusOut),
        .ebusXfer  (ebusXfer),
        .ebusDataIn(ebusDataIn),
        .ebusCS    (ebusCS),
        .ebusFunc  (ebusFunc),
        .ebusDemand(ebusDemand),
        .ebusData  (ebusData),
        .ebusDrive (ebusDrive),
        .ebusIn    (ebusIn),
        .ebusLoad  (ebusLoad),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; write = 1'b0; cs = '0; func = '0;
        ebusOut = '0; ebusXfer = 1'b0; ebusDataIn = '0;
        #2;
        n_tests++;
        if ({ebusCS, ebusFunc, ebusDemand, ebusData, ebusDrive, ebusIn, ebusLoad,
             busy, done, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cs=%o busy=%b done=%b want all zero",
                     ebusCS, busy, done);
        end
        step(); step();
        resetN = 1'b1;
        step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_write();
        int loads = 0;
        int unstable = 0;
        write = 1'b1; cs = 7'o004; func = 3'o2; ebusOut = 36'o123456_701234;
        start = 1'b1;
        step();                                   // T0
        start = 1'b0; ebusOut = '0;
        if (ebusLoad) loads++;
        n_tests++;
        if (busy !== 1'b1 || ebusDemand !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_t0: got busy=%b demand=%b want 1 0", busy, ebusDemand);
        end
        n_tests++;
        if (ebusCS !== 7'o004 || ebusFunc !== 3'o2) begin
            n_fail++;
            $display("FAIL wr_cs_func: got %o/%o want 004/2", ebusCS, ebusFunc);
        end
        n_tests++;
        if (ebusData !== 36'o123456_701234 || ebusDrive !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_data_t0: got %o drive=%b want 123456701234 1",
                     ebusData, ebusDrive);
        end
        step();                                   // T0+1
        if (ebusLoad) loads++;
        n_tests++;
        if (ebusDemand !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_demand_t1: got %b want 0", ebusDemand);
        end
        step();                                   // T0+2
        if (ebusLoad) loads++;
        n_tests++;
        if (ebusDemand !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_demand_t2: got %b want 1", ebusDemand);
        end
        for (int i = 0; i < 2; i++) begin         // T0+3, T0+4
            step();
            if (ebusLoad) loads++;
            if (ebusDemand !== 1'b1 || ebusData !== 36'o123456_701234 || !ebusDrive)
                unstable++;
        end
        ebusXfer = 1'b1;
        step();                                   // T0+5, ack sampled
        if (ebusLoad) loads++;
        if (ebusData !== 36'o123456_701234 || !ebusDrive) unstable++;
        n_tests++;
        if (ebusDemand !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_release: got demand=%b busy=%b done=%b want 0 1 0",
                     ebusDemand, busy, done);
        end
        ebusXfer = 1'b0;
        step();                                   // T0+6
        if (ebusLoad) loads++;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b busy=%b want 1 0", done, busy);
        end
        n_tests++;
        if (ebusCS !== '0 || ebusFunc !== '0 || ebusData !== '0 || ebusDrive !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_bus_free: got cs=%o data=%o drive=%b want 0 0 0",
                     ebusCS, ebusData, ebusDrive);
        end
        step();
        if (ebusLoad) loads++;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_single: got %b want 0", done);
        end
        n_tests++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL wr_stable: got %0d unstable cycles want 0", unstable);
        end
        n_tests++;
        if (loads != 0 || ebusIn !== '0) begin
            n_fail++;
            $display("FAIL wr_no_load: got %0d loads ebusIn=%o want 0 0", loads, ebusIn);
        end
    endtask

    task automatic test_read();
        int drv = 0;
        write = 1'b0; cs = 7'o011; func = 3'o3; ebusOut = 36'o555555_555555;
        start = 1'b1;
        step();                                   // T0
        start = 1'b0;
        if (ebusDrive) drv++;
        n_tests++;
        if (ebusData !== '0 || ebusFunc !== 3'o3) begin
            n_fail++;
            $display("FAIL rd_t0: got data=%o func=%o want 0 3", ebusData, ebusFunc);
        end
        step();
        if (ebusDrive) drv++;
        step();                                   // T0+2
        if (ebusDrive) drv++;
        ebusXfer = 1'b1; ebusDataIn = 36'o777000_000777;
        step();                                   // T0+3
        if (ebusDrive) drv++;
        n_tests++;
        if (ebusIn !== 36'o777000_000777 || ebusLoad !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_capture: got %o load=%b want 777000000777 1", ebusIn, ebusLoad);
        end
        ebusXfer = 1'b0; ebusDataIn = 36'o1;
        step();                                   // T0+4
        if (ebusDrive) drv++;
        n_tests++;
        if (ebusLoad !== 1'b0 || done !== 1'b1 || ebusIn !== 36'o777000_000777) begin
            n_fail++;
            $display("FAIL rd_done: got load=%b done=%b in=%o want 0 1 777000000777",
                     ebusLoad, done, ebusIn);
        end
        n_tests++;
        if (drv != 0) begin
            n_fail++;
            $display("FAIL rd_no_drive: got %0d driven cycles want 0", drv);
        end
        step();
    endtask

    task automatic test_demand_timeout();
        int bad = 0;
        write = 1'b0; cs = 7'o012; func = 3'o1;
        start = 1'b1;
        step();                                   // T0
        start = 1'b0;
        step();
        step();                                   // T0+2, first DEMAND cycle
        for (int i = 0; i < 7; i++) begin
            step();
            if (ebusDemand !== 1'b1 || timeout !== 1'b0 || ebusLoad !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dto_wait: got %0d early-exit cycles want 0", bad);
        end
        step();                                   // T0+10, eighth DEMAND edge
        n_tests++;
        if (timeout !== 1'b1 || ebusIn !== '0 || ebusLoad !== 1'b1 || ebusDemand !== 1'b0) begin
            n_fail++;
            $display("FAIL dto_expire: got to=%b in=%o load=%b dem=%b want 1 0 1 0",
                     timeout, ebusIn, ebusLoad, ebusDemand);
        end
        step();
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b1 || ebusLoad !== 1'b0) begin
            n_fail++;
            $display("FAIL dto_done: got done=%b to=%b load=%b want 1 1 0",
                     done, timeout, ebusLoad);
        end
        // A fresh transaction clears the sticky flag.
        write = 1'b1; cs = 7'o004; func = 3'o0; ebusOut = 36'o1;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dto_clear: got %b want 0", timeout);
        end
        step(); step();
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL dto_next_done: got done=%b to=%b want 1 0", done, timeout);
        end
        step();
    endtask

    task automatic test_release_timeout();
        int bad = 0;
        write = 1'b0; cs = 7'o013; func = 3'o4; ebusDataIn = 36'o123;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();                           // demand up
        ebusXfer = 1'b1;
        step();                                   // Tx
        n_tests++;
        if (ebusIn !== 36'o123 || ebusLoad !== 1'b1 || ebusDemand !== 1'b0) begin
            n_fail++;
            $display("FAIL rto_ack: got in=%o load=%b dem=%b want 123 1 0",
                     ebusIn, ebusLoad, ebusDemand);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rto_wait: got %0d early cycles want 0", bad);
        end
        step();                                   // Tx+8
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rto_expire: got done=%b to=%b busy=%b want 1 1 0",
                     done, timeout, busy);
        end
        ebusXfer = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b0 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL rto_sticky: got done=%b to=%b want 0 1", done, timeout);
        end
    endtask

    task automatic test_busy_reject();
        int dones = 0;
        write = 1'b1; cs = 7'o021; func = 3'o1; ebusOut = 36'o246;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();                           // demand up
        start = 1'b1; write = 1'b0; cs = 7'o055; func = 3'o7; ebusOut = 36'o777;
        step();
        start = 1'b0;
        n_tests++;
        if (ebusCS !== 7'o021 || ebusFunc !== 3'o1 || ebusData !== 36'o246 ||
            ebusDrive !== 1'b1 || ebusDemand !== 1'b1) begin
            n_fail++;
            $display("FAIL rej_bus: got cs=%o f=%o d=%o drv=%b dem=%b want 021 1 246 1 1",
                     ebusCS, ebusFunc, ebusData, ebusDrive, ebusDemand);
        end
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dones++;
        end
        n_tests++;
        if (dones != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_one_done: got %0d dones busy=%b want 1 0", dones, busy);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        write = 1'b1; cs = 7'o044; func = 3'o2; ebusOut = 36'o7070;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();                           // in DEMAND
        n_tests++;
        if (ebusDemand !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got demand=%b want 1", ebusDemand);
        end
        #2;
        resetN = 1'b0;
        #1;                                       // no clock edge in between
        n_tests++;
        if ({ebusCS, ebusFunc, ebusDemand, ebusData, ebusDrive} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: got cs=%o d=%o drv=%b dem=%b want all 0",
                     ebusCS, ebusData, ebusDrive, ebusDemand);
        end
        n_tests++;
        if ({ebusIn, ebusLoad, busy, done, timeout} !== '0) begin
            n_fail++;
            $display("FAIL rst_status: got in=%o busy=%b done=%b to=%b want all 0",
                     ebusIn, busy, done, timeout);
        end
        step();
        if (done) dones++;
        step();
        if (done) dones++;
        resetN = 1'b1;
        step();
        if (done) dones++;
        step();
        if (done) dones++;
        n_tests++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %0d dones want 0", dones);
        end
        write = 1'b0; cs = 7'o001; func = 3'o5;
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || ebusCS !== 7'o001) begin
            n_fail++;
            $display("FAIL rst_restart: got busy=%b cs=%o want 1 001", busy, ebusCS);
        end
        step(); step();
        ebusXfer = 1'b1; ebusDataIn = 36'o42;
        step();
        ebusXfer = 1'b0;
        step();
        n_tests++;
        if (done !== 1'b1 || ebusIn !== 36'o42) begin
            n_fail++;
            $display("FAIL rst_restart_done: got done=%b in=%o want 1 42", done, ebusIn);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_demand_timeout();
        test_release_timeout();
        test_busy_reject();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ebus_ctl.md
# ebus_ctl

EBUS transfer sequencer for the EBOX data path. It accepts a one-cycle I/O request from the microcode control, drives the EBUS controller-select, function and demand lines, and waits for the device's transfer acknowledge. For writes it drives the data path's outgoing EBUS word onto the bus. For reads it captures the bus word into the register that feeds the data path's `ebusIn` (AR load select 011). A cycle counter enforces a device-response timeout.

## Interface
- `SETUP_CYCLES`, default 2: cycles that CS/FUNC are stable before demand asserts (1..15).
- `TIMEOUT`, default 255: maximum cycles spent waiting in each wait state (1..255).
- `clk` in 1: EBOX clock. All state changes on rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request pulse. Ignored unless `busy`=0.
- `write` in 1: 1 = EBOX→device (CONO/DATAO), 0 = device→EBOX (CONI/DATAI). Sampled with `start`.
- `cs` in [0:6]: device controller select. Sampled with `start`.
- `func` in [0:2]: EBUS function. Sampled with `start`.
- `ebusOut` in [0:35]: data path outgoing word. Sampled with `start` when `write`=1.
- `ebusXfer` in 1: device transfer acknowledge, already synchronized.
- `ebusDataIn` in [0:35]: bus data from device.
- `ebusCS` out [0:6]: controller select driven to bus.
- `ebusFunc` out [0:2]: function driven to bus.
- `ebusDemand` out 1: EBOX demand.
- `ebusData` out [0:35]: bus data driven by the EBOX.
- `ebusDrive` out 1: EBOX drives `ebusData`. 1 only on write transactions.
- `ebusIn` out [0:35]: captured read word, to the data path AR/ARX input mux.
- `ebusLoad` out 1: one-cycle pulse when `ebusIn` has been updated.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `timeout` out 1: sticky error flag. Cleared by the next accepted `start`.

## Operation
- States: IDLE, SETUP, DEMAND, RELEASE.
- IDLE:
  - `busy`=0.
  - On `start`: latch `write`, `cs`, `func`, and `ebusOut` (if write); clear `timeout`; load counter with SETUP_CYCLES-1; go to SETUP.
- SETUP:
  - `ebusCS` and `ebusFunc` are driven from the latched values. `ebusDrive`=latched write, with data driven.
  - Counter decrements. At 0, load counter with TIMEOUT-1 and go to DEMAND.
- DEMAND:
  - `ebusDemand`=1.
  - If `ebusXfer`=1: on a read, capture `ebusDataIn` into `ebusIn` and pulse `ebusLoad` the next cycle. Then load counter with TIMEOUT-1 and go to RELEASE.
  - Else if counter=0: set `timeout`. On a read, load `ebusIn` with 0 and pulse `ebusLoad`. Go to RELEASE.
  - Else decrement.
- RELEASE:
  - `ebusDemand`=0. CS/FUNC/data stay driven.
  - When `ebusXfer`=0: pulse `done`, go to IDLE.
  - Else if counter=0: set `timeout`, pulse `done`, go to IDLE.
  - Else decrement.
- In IDLE, `ebusCS`=0, `ebusFunc`=0, `ebusDrive`=0 and `ebusData`=0, so the bus is not held.
- `ebusIn` holds its last value until the next read completes. Writes never modify it.
- `start` while `busy`=1 is dropped with no effect and no latching.
- `ebusXfer`=1 at the moment DEMAND is entered counts as an acknowledge on that first DEMAND cycle.
- Reset, asserted at any time, including mid-transaction:
  - State goes to IDLE.
  - Every output goes to 0: `ebusCS`, `ebusFunc`, `ebusDemand`, `ebusData`, `ebusDrive`, `ebusIn`, `ebusLoad`, `busy`, `done`, `timeout`.
  - The counter clears.
  - No `done` is produced for the aborted transaction.

## Timing
- `start` is seen at edge T0. The state is SETUP from T0 and `busy`=1 from T0.
- `ebusDemand` rises at edge T0+SETUP_CYCLES.
- Device raises `ebusXfer`, sampled at edge Tx:
  - State becomes RELEASE at Tx and `ebusDemand` falls after Tx.
  - `ebusIn` is valid after Tx.
  - `ebusLoad` is high for the cycle after Tx.
- Device drops `ebusXfer`, sampled at edge Tr: `done` is high for one cycle after Tr, `busy`=0 after Tr.
- Back-to-back: a new `start` is accepted on the cycle `done` is high, because state is already IDLE.
- Minimum transaction, with xfer high for one sampled edge: SETUP_CYCLES + 2 cycles from `start` to `done`.
- Worst case: SETUP_CYCLES + 2×TIMEOUT cycles.
- All outputs are registered. There is no combinational path from bus inputs to outputs.

## Test plan
- Reset:
  - Drive `resetN`=0 mid-DEMAND (write, cs=7'o044) -> all outputs 0 immediately, without waiting for a clock.
  - Release reset -> IDLE; a `start` 2 cycles later proceeds normally.
- Write, SETUP_CYCLES=2:
  - `start`, write=1, cs=7'o004, func=3'o2, ebusOut=36'o123456_701234.
  - Device acks 3 cycles after demand and drops 1 cycle later.
  - Required: demand rises at T0+2; ebusData/ebusDrive stable from T0 to `done`; `ebusLoad` never pulses; `done` is a single cycle.
- Read:
  - `start`, write=0, func=3'o3; device acks with ebusDataIn=36'o777000_000777.
  - Required: `ebusIn`=36'o777000_000777 with `ebusLoad` one cycle; `ebusDrive`=0 throughout.
- Demand timeout, TIMEOUT=8, read, no ack:
  - Required: 8 cycles in DEMAND, then `timeout`=1, `ebusIn`=0, `ebusLoad` pulses, `done` follows.
  - A following successful `start` clears `timeout`.
- Release timeout:
  - Device holds xfer high forever after ack.
  - Required: `done` and `timeout`=1 after TIMEOUT cycles in RELEASE.
- Busy rejection:
  - `start` pulsed during DEMAND with different cs/func.
  - Required: bus lines are unchanged and exactly one `done` occurs.
